alu_share_arbiter: RTL
======================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin, 1 = requester 0 always wins.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-003 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have reqN_valid  input  1  request N (N=0,1) payload valid.
REQ-005 SHALL have reqN_ready  output  1  request N accepted this cycle.
REQ-006 SHALL have reqN_opcode  input  7  RISC-V opcode.
REQ-007 SHALL have reqN_fn_3  input  3  funct3.
REQ-008 SHALL have reqN_fn_7  input  7  funct7.
REQ-009 SHALL have reqN_a  input  32  operand rs1.
REQ-010 SHALL have reqN_b  input  32  operand rs2/immediate.
REQ-011 SHALL have rsp_valid  output  1  result held.
REQ-012 SHALL have rsp_ready  input  1  consumer takes result.
REQ-013 SHALL have rsp_id  output  1  requester index owning result.
REQ-014 SHALL have rsp_result  output  32  ALU result.
REQ-015 SHALL have rsp_illegal  output  1  opcode not R-type (0110011), I-type (0010011) or LOAD (0000011).

Function
REQ-016 SHALL define can_accept = !rsp_valid || rsp_ready.
REQ-017 SHALL combinationally grant at most one requester per cycle; reqN_ready = grantN && can_accept.
REQ-018 SHALL assert reqN_ready only when reqN_valid is high.
REQ-019 SHALL grant the sole valid requester whenever exactly one is valid.
REQ-020 SHALL, with both valid and FIXED_PRIO=0, grant the requester not granted by the last accepted transfer; with FIXED_PRIO=1, grant requester 0.
REQ-021 SHALL update the last-granted pointer only on an accepted transfer (valid && ready), never on a stall.
REQ-022 SHALL require a requester to hold valid and payload stable until ready; the arbiter need not tolerate withdrawal.
REQ-023 SHALL register the accepted request's ALU result, id and illegal flag, raising rsp_valid the next cycle (latency 1).
REQ-024 SHALL hold rsp_valid, rsp_result, rsp_id and rsp_illegal stable while rsp_valid && !rsp_ready.
REQ-025 SHALL sustain one transfer per cycle while rsp_ready stays high (accept and retire in the same cycle).
REQ-026 SHALL clear rsp_valid on rsp_ready when no new request is accepted that cycle.
REQ-027 SHALL compute results per RV32I: R-type ADD/SUB (fn_7 bit 5), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; I-type same with SRAI on imm[10]; LOAD = a + b (address).
REQ-028 SHALL apply shift amounts from b[4:0] only; arithmetic shifts SHALL sign-fill.
REQ-029 SHALL use 32-bit wrap-around arithmetic with no overflow flag.
REQ-030 SHALL, for an illegal opcode, accept the request normally, return rsp_result = 0 and rsp_illegal = 1.
REQ-031 SHALL implement a two-state machine: IDLE (rsp_valid=0) -> HOLD on accept; HOLD -> HOLD on accept with rsp_ready or on stall; HOLD -> IDLE on rsp_ready without accept.

Reset
REQ-032 SHALL, on rst_n low, asynchronously force state IDLE, rsp_valid=0, rsp_result=0, rsp_id=0, rsp_illegal=0, last-granted=1 (requester 0 wins first).
REQ-033 SHALL discard any held result when reset asserts mid-operation; no transfer completes in a reset cycle.
REQ-034 SHALL hold reqN_ready low while rst_n is low.

Structure
REQ-035 SHALL place opcode constants (R_TYPE, I_TYPE, LOAD), funct3 codes and the state encoding in a shared package alu_pkg.
REQ-036 SHALL instantiate the existing combinational alu module once as its only sub-module, fed by the muxed granted payload.

Verification
REQ-037 SHALL check: after reset, req0 ADD a=5 b=7 -> req0_ready that cycle, next cycle rsp_valid=1, rsp_result=12, rsp_id=0.
REQ-038 SHALL check: both valid for 4 cycles, rsp_ready=1, FIXED_PRIO=0 -> grants 0,1,0,1; with FIXED_PRIO=1 -> 0,0,0,0.
REQ-039 SHALL check: rsp_ready low 3 cycles with result 0xFFFFFFF0 held -> outputs unchanged, both reqN_ready=0, pointer unchanged.
REQ-040 SHALL check: req1 SRA (fn_7=0100000) a=0x80000000 b=4 -> rsp_result=0xF8000000; SUB a=0 b=1 -> 0xFFFFFFFF.
REQ-041 SHALL check: opcode 1100011 -> rsp_illegal=1, rsp_result=0; rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared RV32I decode constants, request payload type and arbiter state encoding.
package alu_pkg;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef enum logic {
      StIdle,
      StHold
   } state_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  fn_3;
      logic [6:0]  fn_7;
      logic [31:0] a;
      logic [31:0] b;
   } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two request channels plus one response channel of the shared-ALU arbiter.
interface alu_share_arbiter_if;

   logic        req0_valid;
   logic        req0_ready;
   logic [6:0]  req0_opcode;
   logic [2:0]  req0_fn_3;
   logic [6:0]  req0_fn_7;
   logic [31:0] req0_a;
   logic [31:0] req0_b;

   logic        req1_valid;
   logic        req1_ready;
   logic [6:0]  req1_opcode;
   logic [2:0]  req1_fn_3;
   logic [6:0]  req1_fn_7;
   logic [31:0] req1_a;
   logic [31:0] req1_b;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_illegal;

   modport master (
      output req0_valid, req0_opcode, req0_fn_3, req0_fn_7, req0_a, req0_b,
      output req1_valid, req1_opcode, req1_fn_3, req1_fn_7, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_illegal
   );

   modport slave (
      input  req0_valid, req0_opcode, req0_fn_3, req0_fn_7, req0_a, req0_b,
      input  req1_valid, req1_opcode, req1_fn_3, req1_fn_7, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_illegal
   );

endinterface

// File: rtl/alu.sv
// Combinational RV32I integer ALU: R-type, I-type and LOAD address generation.
// Any other opcode yields a zero result and raises illegal_o.
module alu
   import alu_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  fn_3_i,
   input  logic [6:0]  fn_7_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o,
   output logic        illegal_o
);

   logic        is_r;
   logic        alt;
   logic [4:0]  shamt;
   logic [31:0] sra_res;
   logic        unused_fn_7;

   assign is_r        = (opcode_i == R_TYPE);
   // R-type picks SUB/SRA from funct7[5]; I-type has no SUBI and takes SRAI from imm[10]
   assign alt         = is_r ? fn_7_i[5] : b_i[10];
   assign shamt       = b_i[4:0];
   assign sra_res     = $signed(a_i) >>> shamt;
   assign unused_fn_7 = ^{fn_7_i[6], fn_7_i[4:0]};

   always_comb begin
      result_o  = '0;
      illegal_o = 1'b0;
      if (opcode_i == LOAD) begin
         result_o = a_i + b_i;
      end else if (is_r || (opcode_i == I_TYPE)) begin
         case (fn_3_i)
            F3_ADD:  result_o = (is_r && alt) ? (a_i - b_i) : (a_i + b_i);
            F3_SLL:  result_o = a_i << shamt;
            F3_SLT:  result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            F3_SLTU: result_o = {31'd0, (a_i < b_i)};
            F3_XOR:  result_o = a_i ^ b_i;
            F3_SR:   result_o = alt ? sra_res : (a_i >> shamt);
            F3_OR:   result_o = a_i | b_i;
            F3_AND:  result_o = a_i & b_i;
            default: result_o = '0;
         endcase
      end else begin
         illegal_o = 1'b1;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared ALU with a single registered result slot.
// Round-robin or fixed-priority grant; a held result stalls both requesters until consumed.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input logic                clk,
   input logic                rst_n,
   alu_share_arbiter_if.slave bus_io
);

   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic [31:0] result_q, result_d;
   logic        id_q, id_d;
   logic        illegal_q, illegal_d;

   logic        grant0, grant1;
   logic        can_accept, accept, sel;
   alu_req_t    req0, req1, req_sel;
   logic [31:0] alu_result;
   logic        alu_illegal;

   assign req0 = {bus_io.req0_opcode, bus_io.req0_fn_3, bus_io.req0_fn_7,
                  bus_io.req0_a, bus_io.req0_b};
   assign req1 = {bus_io.req1_opcode, bus_io.req1_fn_3, bus_io.req1_fn_7,
                  bus_io.req1_a, bus_io.req1_b};

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (bus_io.req0_valid && bus_io.req1_valid) begin
         // last_q holds the winner of the most recent accepted transfer
         if (FIXED_PRIO || last_q) begin
            grant0 = 1'b1;
         end else begin
            grant1 = 1'b1;
         end
      end else begin
         grant0 = bus_io.req0_valid;
         grant1 = bus_io.req1_valid;
      end
   end

   assign can_accept        = (state_q == StIdle) || bus_io.rsp_ready;
   assign bus_io.req0_ready = rst_n && grant0 && can_accept;
   assign bus_io.req1_ready = rst_n && grant1 && can_accept;
   assign accept            = bus_io.req0_ready || bus_io.req1_ready;
   assign sel               = grant1;
   assign req_sel           = sel ? req1 : req0;

   alu u_alu (
      .opcode_i  (req_sel.opcode),
      .fn_3_i    (req_sel.fn_3),
      .fn_7_i    (req_sel.fn_7),
      .a_i       (req_sel.a),
      .b_i       (req_sel.b),
      .result_o  (alu_result),
      .illegal_o (alu_illegal)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      result_d  = result_q;
      id_d      = id_q;
      illegal_d = illegal_q;
      if (accept) begin
         result_d  = alu_result;
         id_d      = sel;
         illegal_d = alu_illegal;
         last_d    = sel;
      end
      case (state_q)
         StIdle:  if (accept) state_d = StHold;
         StHold:  if (!accept && bus_io.rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         result_q  <= '0;
         id_q      <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         result_q  <= result_d;
         id_q      <= id_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus_io.rsp_valid   = (state_q == StHold);
   assign bus_io.rsp_result  = result_q;
   assign bus_io.rsp_id      = id_q;
   assign bus_io.rsp_illegal = illegal_q;

endmodule
